dmem_io_ctrl: RTL

Multi-cycle access sequencer for the CPU's data memory port and the memory-mapped IO region (0xFFFFFC00–0xFFFFFFFF). It sits between the load/store stage and the synchronous-read data BRAM / IO devices. It shares the single BRAM port between CPU accesses and the UART program loader, stalls the CPU until each access completes, and performs lw/lb/lbu lane extraction.

---
 rtl/dmem_io_ctrl_pkg.sv | 40 ++++
 rtl/dmem_io_ctrl_if.sv | 80 ++++++++
 rtl/dmem_io_ctrl_load_extend.sv | 46 ++++
 rtl/dmem_io_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dmem_io_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory / IO access sequencer.
//   - state_t      : access sequencer FSM states
//   - IO_BASE_HI   : upper 22 address bits that select the memory-mapped IO
//                    window 0xFFFFFC00..0xFFFFFFFF (the instruction decoder's
//                    IoRead/IoWrite logic uses the same constant)
//   - LANE_B*      : byte-lane selectors inside a 32-bit little-endian word
//   - helpers      : IO window decode and misalignment test
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEM_RD = 2'd1,
        ST_RESP   = 2'd2,
        ST_LD_ACK = 2'd3
    } state_t;

    localparam logic [21:0] IO_BASE_HI = 22'h3FFFFF;

    // Byte lanes, little-endian: lane 0 is bits 7:0.
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    // True when a byte address falls inside the IO window.
    function automatic logic is_io_addr(input logic [31:0] addr);
        return addr[31:10] == IO_BASE_HI;
    endfunction

    // Word accesses (every store, and lw) must be 4-byte aligned.
    // Byte loads may use any lane.
    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic       is_word);
        return is_word && (addr_lo != LANE_B0);
    endfunction

endpackage

// File: rtl/dmem_io_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_io_ctrl_if
//   Bundles the CPU load/store port, the UART loader write port, the BRAM
//   port and the IO device port seen by dmem_io_ctrl.
//
//   Handshakes:
//   - CPU: cpu_req is held high (with cpu_we/cpu_byte/cpu_unsigned/cpu_addr/
//     cpu_wdata stable) until the one-cycle cpu_done pulse. cpu_rdata and
//     cpu_err are valid only in the cpu_done cycle. cpu_stall = cpu_req &
//     ~cpu_done. A cpu_req still high in the cycle after cpu_done starts a
//     new access.
//   - Loader: ld_req is held with ld_addr/ld_wdata until the one-cycle ld_ack
//     pulse, which means the word has been written to BRAM.
//   - BRAM: mem_en/mem_we single-cycle strobes; mem_rdata valid the cycle
//     after a read strobe.
//   - IO: io_rd/io_wr single-cycle strobes; io_rdata is combinational from
//     io_addr.
//   All mem_* and io_* outputs are zero whenever they are not strobed.
//
//   Modports: slave = the sequencer, master = CPU/loader/BRAM/IO side.
// -----------------------------------------------------------------------------
interface dmem_io_ctrl_if #(
    parameter int MEM_AW = 14,
    parameter int IO_AW  = 10
);
    // CPU load/store port
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_byte;
    logic              cpu_unsigned;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_done;
    logic              cpu_err;
    logic              cpu_stall;

    // UART program loader
    logic              ld_req;
    logic [MEM_AW-1:0] ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_ack;

    // Data BRAM (synchronous read)
    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // IO devices (combinational read)
    logic              io_rd;
    logic              io_wr;
    logic [IO_AW-1:0]  io_addr;
    logic [31:0]       io_wdata;
    logic [31:0]       io_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_byte, cpu_unsigned, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_err, cpu_stall,
        input  ld_req, ld_addr, ld_wdata,
        output ld_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output io_rd, io_wr, io_addr, io_wdata,
        input  io_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_byte, cpu_unsigned, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_err, cpu_stall,
        output ld_req, ld_addr, ld_wdata,
        input  ld_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  io_rd, io_wr, io_addr, io_wdata,
        output io_rdata
    );

endinterface

// File: rtl/dmem_io_ctrl_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
//   Combinational load-result formatter.
//   Ports:
//     rdata_q     in  32 : captured memory/IO word
//     addr        in  2  : byte address bits [1:0] of the access
//     is_byte     in  1  : byte load (lb/lbu)
//     is_unsigned in  1  : zero-extend instead of sign-extend
//     result      out 32 : value returned to the register file
//   Word loads pass through unchanged. The lane mux is kept separate from the
//   extension so a halfword path (lh/lhu) can be added alongside it.
// -----------------------------------------------------------------------------
module load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] rdata_q,
    input  logic [1:0]  addr,
    input  logic        is_byte,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0] lane_byte;

    always_comb begin
        lane_byte = 8'h00;
        case (addr)
            LANE_B0: lane_byte = rdata_q[7:0];
            LANE_B1: lane_byte = rdata_q[15:8];
            LANE_B2: lane_byte = rdata_q[23:16];
            LANE_B3: lane_byte = rdata_q[31:24];
            default: lane_byte = 8'h00;
        endcase
    end

    always_comb begin
        if (!is_byte) begin
            result = rdata_q;
        end else if (is_unsigned) begin
            result = {24'h000000, lane_byte};
        end else begin
            result = {{24{lane_byte[7]}}, lane_byte};
        end
    end

endmodule

// File: rtl/dmem_io_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_io_ctrl
//   Multi-cycle access sequencer between the load/store stage and the data
//   BRAM / memory-mapped IO window. Shares the single BRAM port with the UART
//   program loader (loader wins ties in IDLE, never preempts a CPU access),
//   stalls the CPU until each access completes and formats lw/lb/lbu results.
//
//   Ports:
//     clk       in  : single clock, rising edge
//     rst       in  : synchronous, active-high reset
//     bus       if  : dmem_io_ctrl_if.slave (CPU, loader, BRAM, IO ports)
//     dbg_state out : current sequencer state
//
//   Latency from acceptance in IDLE (cycle N):
//     BRAM load -> cpu_done at N+2; BRAM store, IO load/store, misaligned
//     -> cpu_done at N+1; loader write -> ld_ack at N+1.
// -----------------------------------------------------------------------------
module dmem_io_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_AW = 14,
    parameter int IO_AW  = 10
) (
    input  logic          clk,
    input  logic          rst,
    dmem_io_ctrl_if.slave bus,
    output state_t        dbg_state
);

    state_t      state;
    logic [31:0] rdata_q;
    logic [1:0]  lane_q;
    logic        byte_q;
    logic        unsigned_q;
    logic        done_q;
    logic        err_q;
    logic        ld_ack_q;
    logic [31:0] ext_data;

    // Request decode, meaningful only in IDLE.
    logic io_hit;
    logic misaligned;
    logic accept_ld;
    logic accept_cpu;

    assign io_hit     = is_io_addr(bus.cpu_addr);
    assign misaligned = is_misaligned(bus.cpu_addr[1:0],
                                      bus.cpu_we | ~bus.cpu_byte);
    assign accept_ld  = (state == ST_IDLE) & bus.ld_req;
    assign accept_cpu = (state == ST_IDLE) & ~bus.ld_req & bus.cpu_req;

    // -------------------------------------------------------------------------
    // Bus strobes are issued in the same cycle the request is accepted, so
    // they are decoded from IDLE + inputs rather than registered. Address and
    // data buses are gated to zero outside their strobe cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0;
        bus.io_rd     = 1'b0;
        bus.io_wr     = 1'b0;
        bus.io_addr   = '0;
        bus.io_wdata  = 32'h0;

        if (accept_ld) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.ld_addr;
            bus.mem_wdata = bus.ld_wdata;
        end else if (accept_cpu && !misaligned) begin
            if (io_hit) begin
                bus.io_addr = bus.cpu_addr[IO_AW-1:0];
                if (bus.cpu_we) begin
                    bus.io_wr    = 1'b1;
                    bus.io_wdata = bus.cpu_wdata;
                end else begin
                    bus.io_rd = 1'b1;
                end
            end else begin
                // Upper address bits above the BRAM word range are ignored.
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.cpu_addr[MEM_AW+1:2];
                if (bus.cpu_we) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = bus.cpu_wdata;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer. done/err/ld_ack are registered on entry to RESP/LD_ACK so
    // they are high for exactly the one cycle spent in those states.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rdata_q    <= 32'h0;
            lane_q     <= LANE_B0;
            byte_q     <= 1'b0;
            unsigned_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ld_ack_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ld_ack_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept_ld) begin
                        ld_ack_q <= 1'b1;
                        state    <= ST_LD_ACK;
                    end else if (accept_cpu) begin
                        lane_q     <= bus.cpu_addr[1:0];
                        byte_q     <= bus.cpu_byte;
                        unsigned_q <= bus.cpu_unsigned;
                        if (misaligned) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= ST_RESP;
                        end else if (io_hit) begin
                            // IO devices answer combinationally during io_rd.
                            if (!bus.cpu_we) begin
                                rdata_q <= bus.io_rdata;
                            end
                            done_q <= 1'b1;
                            state  <= ST_RESP;
                        end else if (bus.cpu_we) begin
                            done_q <= 1'b1;
                            state  <= ST_RESP;
                        end else begin
                            state <= ST_MEM_RD;
                        end
                    end
                end

                ST_MEM_RD: begin
                    rdata_q <= bus.mem_rdata;
                    done_q  <= 1'b1;
                    state   <= ST_RESP;
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                end

                ST_LD_ACK: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    load_extend u_load_extend (
        .rdata_q     (rdata_q),
        .addr        (lane_q),
        .is_byte     (byte_q),
        .is_unsigned (unsigned_q),
        .result      (ext_data)
    );

    assign bus.cpu_rdata = ext_data;
    assign bus.cpu_done  = done_q;
    assign bus.cpu_err   = err_q;
    assign bus.cpu_stall = bus.cpu_req & ~done_q;
    assign bus.ld_ack    = ld_ack_q;
    assign dbg_state     = state;

endmodule
